// File: rtl/data_demux_32_w_shadow.sv
// 32-way write demultiplexer into a shadow bank, with an atomic commit that
// copies every shadow word to its output register on the same edge.
module data_demux_32_w_shadow #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              data_lock,
  input  logic [7:0]        selector,
  input  logic [DATA_W-1:0] data_in,
  input  logic              commit,
  output logic [DATA_W-1:0] data_0,
  output logic [DATA_W-1:0] data_1,
  output logic [DATA_W-1:0] data_2,
  output logic [DATA_W-1:0] data_3,
  output logic [DATA_W-1:0] data_4,
  output logic [DATA_W-1:0] data_5,
  output logic [DATA_W-1:0] data_6,
  output logic [DATA_W-1:0] data_7,
  output logic [DATA_W-1:0] data_8,
  output logic [DATA_W-1:0] data_9,
  output logic [DATA_W-1:0] data_10,
  output logic [DATA_W-1:0] data_11,
  output logic [DATA_W-1:0] data_12,
  output logic [DATA_W-1:0] data_13,
  output logic [DATA_W-1:0] data_14,
  output logic [DATA_W-1:0] data_15,
  output logic [DATA_W-1:0] data_16,
  output logic [DATA_W-1:0] data_17,
  output logic [DATA_W-1:0] data_18,
  output logic [DATA_W-1:0] data_19,
  output logic [DATA_W-1:0] data_20,
  output logic [DATA_W-1:0] data_21,
  output logic [DATA_W-1:0] data_22,
  output logic [DATA_W-1:0] data_23,
  output logic [DATA_W-1:0] data_24,
  output logic [DATA_W-1:0] data_25,
  output logic [DATA_W-1:0] data_26,
  output logic [DATA_W-1:0] data_27,
  output logic [DATA_W-1:0] data_28,
  output logic [DATA_W-1:0] data_29,
  output logic [DATA_W-1:0] data_30,
  output logic [DATA_W-1:0] data_31,
  output logic              wr_ack,
  output logic              addr_err,
  output logic              commit_ack,
  output logic              dirty,
  output logic [15:0]       wr_count
);

  logic                          lock_d;
  logic                          commit_d;
  logic [31:0][DATA_W-1:0]       shadow_reg;
  logic [31:0][DATA_W-1:0]       out_reg;
  logic                          wr_ack_reg;
  logic                          addr_err_reg;
  logic                          commit_ack_reg;
  logic                          dirty_reg;
  logic [15:0]                   wr_count_reg;

  logic write_ev;
  logic commit_ev;
  logic addr_ok;
  logic wr_accept;

  assign write_ev  = data_lock & ~lock_d & ~reset;
  assign commit_ev = commit & ~commit_d & ~reset;
  assign addr_ok   = (selector[7:5] == 3'd0);
  assign wr_accept = write_ev & addr_ok;

  // Edge detectors keep tracking during reset so a strobe held across
  // reset release is not seen as a fresh event.
  always_ff @(posedge clk) begin
    lock_d   <= data_lock;
    commit_d <= commit;
  end

  // Commit reads the pre-write shadow value when both events share an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_reg     <= '0;
      out_reg        <= '0;
      wr_ack_reg     <= 1'b0;
      addr_err_reg   <= 1'b0;
      commit_ack_reg <= 1'b0;
      dirty_reg      <= 1'b0;
      wr_count_reg   <= 16'd0;
    end else begin
      wr_ack_reg     <= wr_accept;
      addr_err_reg   <= write_ev & ~addr_ok;
      commit_ack_reg <= commit_ev;
      if (commit_ev)
        out_reg <= shadow_reg;
      for (int i = 0; i < 32; i++) begin
        if (wr_accept && (selector[4:0] == 5'(i)))
          shadow_reg[i] <= data_in;
      end
      if (wr_accept) begin
        dirty_reg    <= 1'b1;
        wr_count_reg <= wr_count_reg + 16'd1;
      end else if (commit_ev) begin
        dirty_reg <= 1'b0;
      end
    end
  end

  assign wr_ack     = wr_ack_reg;
  assign addr_err   = addr_err_reg;
  assign commit_ack = commit_ack_reg;
  assign dirty      = dirty_reg;
  assign wr_count   = wr_count_reg;

  assign data_0  = out_reg[0];
  assign data_1  = out_reg[1];
  assign data_2  = out_reg[2];
  assign data_3  = out_reg[3];
  assign data_4  = out_reg[4];
  assign data_5  = out_reg[5];
  assign data_6  = out_reg[6];
  assign data_7  = out_reg[7];
  assign data_8  = out_reg[8];
  assign data_9  = out_reg[9];
  assign data_10 = out_reg[10];
  assign data_11 = out_reg[11];
  assign data_12 = out_reg[12];
  assign data_13 = out_reg[13];
  assign data_14 = out_reg[14];
  assign data_15 = out_reg[15];
  assign data_16 = out_reg[16];
  assign data_17 = out_reg[17];
  assign data_18 = out_reg[18];
  assign data_19 = out_reg[19];
  assign data_20 = out_reg[20];
  assign data_21 = out_reg[21];
  assign data_22 = out_reg[22];
  assign data_23 = out_reg[23];
  assign data_24 = out_reg[24];
  assign data_25 = out_reg[25];
  assign data_26 = out_reg[26];
  assign data_27 = out_reg[27];
  assign data_28 = out_reg[28];
  assign data_29 = out_reg[29];
  assign data_30 = out_reg[30];
  assign data_31 = out_reg[31];

endmodule

// File: tb/tb_data_demux_32_w_shadow.sv
// Directed bench for data_demux_32_w_shadow: writes, commits, address errors,
// coincident events, held strobes, reset behaviour and counter wrap.
module tb_data_demux_32_w_shadow;

  logic        clk = 1'b0;
  logic        reset;
  logic        data_lock;
  logic [7:0]  selector;
  logic [15:0] data_in;
  logic        commit;
  logic        wr_ack, addr_err, commit_ack, dirty;
  logic [15:0] wr_count;
  logic [15:0] outs [32];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  data_demux_32_w_shadow #(.DATA_W(16)) dut (
    .clk(clk), .reset(reset), .data_lock(data_lock), .selector(selector),
    .data_in(data_in), .commit(commit),
    .data_0(outs[0]),   .data_1(outs[1]),   .data_2(outs[2]),   .data_3(outs[3]),
    .data_4(outs[4]),   .data_5(outs[5]),   .data_6(outs[6]),   .data_7(outs[7]),
    .data_8(outs[8]),   .data_9(outs[9]),   .data_10(outs[10]), .data_11(outs[11]),
    .data_12(outs[12]), .data_13(outs[13]), .data_14(outs[14]), .data_15(outs[15]),
    .data_16(outs[16]), .data_17(outs[17]), .data_18(outs[18]), .data_19(outs[19]),
    .data_20(outs[20]), .data_21(outs[21]), .data_22(outs[22]), .data_23(outs[23]),
    .data_24(outs[24]), .data_25(outs[25]), .data_26(outs[26]), .data_27(outs[27]),
    .data_28(outs[28]), .data_29(outs[29]), .data_30(outs[30]), .data_31(outs[31]),
    .wr_ack(wr_ack), .addr_err(addr_err), .commit_ack(commit_ack),
    .dirty(dirty), .wr_count(wr_count)
  );

  // One-cycle write strobe; returns on the negedge where wr_ack/addr_err show.
  task automatic do_write(input logic [7:0] sel, input logic [15:0] d, input logic with_commit);
    @(negedge clk);
    data_lock = 1'b1; selector = sel; data_in = d; commit = with_commit;
    @(negedge clk);
    data_lock = 1'b0; commit = 1'b0;
    selector = 8'($urandom); data_in = 16'($urandom);
    $display("write sel=%0d data=%h commit=%0b -> wr_ack=%0b addr_err=%0b count=%h",
             sel, d, with_commit, wr_ack, addr_err, wr_count);
  endtask

  task automatic do_commit();
    @(negedge clk);
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    $display("commit -> commit_ack=%0b dirty=%0b", commit_ack, dirty);
  endtask

  task automatic apply_reset(input int cycles);
    @(negedge clk);
    reset = 1'b1;
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    data_lock = 1'b0; commit = 1'b0; selector = 8'd0; data_in = 16'd0;
    apply_reset(3);
    checks++; if (wr_count !== 16'd0) begin errors++; $display("FAIL reset_count got=%h exp=0000", wr_count); end
    checks++; if (dirty !== 1'b0) begin errors++; $display("FAIL reset_dirty got=%b exp=0", dirty); end
    checks++; if ({wr_ack, addr_err, commit_ack} !== 3'b000) begin errors++; $display("FAIL reset_pulses got=%b exp=000", {wr_ack, addr_err, commit_ack}); end
    for (int i = 0; i < 32; i++) begin
      checks++; if (outs[i] !== 16'd0) begin errors++; $display("FAIL reset_data_%0d got=%h exp=0000", i, outs[i]); end
    end
  endtask

  task automatic test_write_commit();
    do_write(8'd5, 16'hABCD, 1'b0);
    checks++; if (wr_ack !== 1'b1) begin errors++; $display("FAIL wc_wr_ack got=%b exp=1", wr_ack); end
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL wc_addr_err got=%b exp=0", addr_err); end
    checks++; if (dirty !== 1'b1) begin errors++; $display("FAIL wc_dirty got=%b exp=1", dirty); end
    checks++; if (wr_count !== 16'd1) begin errors++; $display("FAIL wc_count got=%h exp=0001", wr_count); end
    checks++; if (outs[5] !== 16'h0000) begin errors++; $display("FAIL wc_data5_precommit got=%h exp=0000", outs[5]); end
    @(negedge clk);
    checks++; if (wr_ack !== 1'b0) begin errors++; $display("FAIL wc_wr_ack_drop got=%b exp=0", wr_ack); end
    do_commit();
    checks++; if (commit_ack !== 1'b1) begin errors++; $display("FAIL wc_commit_ack got=%b exp=1", commit_ack); end
    checks++; if (outs[5] !== 16'hABCD) begin errors++; $display("FAIL wc_data5 got=%h exp=abcd", outs[5]); end
    checks++; if (dirty !== 1'b0) begin errors++; $display("FAIL wc_dirty_clear got=%b exp=0", dirty); end
    for (int i = 0; i < 32; i++) begin
      if (i != 5) begin
        checks++; if (outs[i] !== 16'd0) begin errors++; $display("FAIL wc_other_data_%0d got=%h exp=0000", i, outs[i]); end
      end
    end
    @(negedge clk);
    checks++; if (commit_ack !== 1'b0) begin errors++; $display("FAIL wc_commit_ack_drop got=%b exp=0", commit_ack); end
  endtask

  task automatic test_addr_err();
    do_write(8'd32, 16'h1234, 1'b0);
    checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL ae_addr_err got=%b exp=1", addr_err); end
    checks++; if (wr_ack !== 1'b0) begin errors++; $display("FAIL ae_wr_ack got=%b exp=0", wr_ack); end
    checks++; if (wr_count !== 16'd1) begin errors++; $display("FAIL ae_count got=%h exp=0001", wr_count); end
    checks++; if (dirty !== 1'b0) begin errors++; $display("FAIL ae_dirty got=%b exp=0", dirty); end
    do_write(8'd255, 16'h4321, 1'b0);
    checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL ae255_addr_err got=%b exp=1", addr_err); end
    do_commit();
    checks++; if (outs[0] !== 16'h0000) begin errors++; $display("FAIL ae_data0 got=%h exp=0000", outs[0]); end
    checks++; if (outs[5] !== 16'hABCD) begin errors++; $display("FAIL ae_data5 got=%h exp=abcd", outs[5]); end
    checks++; if (outs[31] !== 16'h0000) begin errors++; $display("FAIL ae_data31 got=%h exp=0000", outs[31]); end
    checks++; if (commit_ack !== 1'b1) begin errors++; $display("FAIL ae_clean_commit_ack got=%b exp=1", commit_ack); end
  endtask

  task automatic test_coincide();
    do_write(8'd3, 16'h5555, 1'b1);
    checks++; if ({wr_ack, commit_ack} !== 2'b11) begin errors++; $display("FAIL co_acks got=%b exp=11", {wr_ack, commit_ack}); end
    checks++; if (outs[3] !== 16'h0000) begin errors++; $display("FAIL co_data3_old got=%h exp=0000", outs[3]); end
    checks++; if (dirty !== 1'b1) begin errors++; $display("FAIL co_dirty got=%b exp=1", dirty); end
    checks++; if (wr_count !== 16'd2) begin errors++; $display("FAIL co_count got=%h exp=0002", wr_count); end
    do_write(8'd31, 16'hBEEF, 1'b0);
    checks++; if (outs[31] !== 16'h0000) begin errors++; $display("FAIL co_data31_hold got=%h exp=0000", outs[31]); end
    do_commit();
    checks++; if (outs[3] !== 16'h5555) begin errors++; $display("FAIL co_data3_new got=%h exp=5555", outs[3]); end
    checks++; if (outs[31] !== 16'hBEEF) begin errors++; $display("FAIL co_data31 got=%h exp=beef", outs[31]); end
    checks++; if (dirty !== 1'b0) begin errors++; $display("FAIL co_dirty_clear got=%b exp=0", dirty); end
  endtask

  task automatic test_held_strobes();
    int acks = 0;
    @(negedge clk);
    data_lock = 1'b1; selector = 8'd7; data_in = 16'h1111;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      selector = 8'd8; data_in = 16'h2222 + 16'(c);
      if (wr_ack === 1'b1) acks++;
    end
    data_lock = 1'b0;
    @(negedge clk);
    if (wr_ack === 1'b1) acks++;
    $display("held data_lock 10 cycles -> wr_ack pulses=%0d count=%h", acks, wr_count);
    checks++; if (acks !== 1) begin errors++; $display("FAIL held_lock_acks got=%0d exp=1", acks); end
    checks++; if (wr_count !== 16'd4) begin errors++; $display("FAIL held_lock_count got=%h exp=0004", wr_count); end
    acks = 0;
    commit = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (commit_ack === 1'b1) acks++;
    end
    commit = 1'b0;
    @(negedge clk);
    if (commit_ack === 1'b1) acks++;
    $display("held commit 5 cycles -> commit_ack pulses=%0d", acks);
    checks++; if (acks !== 1) begin errors++; $display("FAIL held_commit_acks got=%0d exp=1", acks); end
    checks++; if (outs[7] !== 16'h1111) begin errors++; $display("FAIL held_data7 got=%h exp=1111", outs[7]); end
    checks++; if (outs[8] !== 16'h0000) begin errors++; $display("FAIL held_data8 got=%h exp=0000", outs[8]); end
  endtask

  task automatic test_reset_interactions();
    int acks = 0;
    // Uncommitted write is discarded by reset.
    do_write(8'd9, 16'hAAAA, 1'b0);
    apply_reset(1);
    do_commit();
    checks++; if (outs[9] !== 16'h0000) begin errors++; $display("FAIL rst_discard_data9 got=%h exp=0000", outs[9]); end
    checks++; if (outs[7] !== 16'h0000) begin errors++; $display("FAIL rst_clear_data7 got=%h exp=0000", outs[7]); end
    // Strobe held high across reset release must not create a write.
    @(negedge clk);
    reset = 1'b1; data_lock = 1'b1; selector = 8'd2; data_in = 16'h7777;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (wr_ack === 1'b1) acks++;
    end
    data_lock = 1'b0;
    $display("data_lock held across reset release -> wr_ack pulses=%0d count=%h", acks, wr_count);
    checks++; if (acks !== 0) begin errors++; $display("FAIL rst_held_acks got=%0d exp=0", acks); end
    checks++; if (wr_count !== 16'd0) begin errors++; $display("FAIL rst_held_count got=%h exp=0000", wr_count); end
    checks++; if (dirty !== 1'b0) begin errors++; $display("FAIL rst_held_dirty got=%b exp=0", dirty); end
    do_commit();
    checks++; if (outs[2] !== 16'h0000) begin errors++; $display("FAIL rst_held_data2 got=%h exp=0000", outs[2]); end
  endtask

  task automatic test_wrap();
    apply_reset(1);
    do_write(8'd0, 16'h0F0F, 1'b0);
    checks++; if (wr_count !== 16'd1) begin errors++; $display("FAIL wrap_first got=%h exp=0001", wr_count); end
    // Jump the counter close to its top instead of clocking 65k writes.
    @(negedge clk);
    force dut.wr_count_reg = 16'hFFFD;
    @(negedge clk);
    release dut.wr_count_reg;
    @(negedge clk);
    checks++; if (wr_count !== 16'hFFFD) begin errors++; $display("FAIL wrap_preset got=%h exp=fffd", wr_count); end
    do_write(8'd1, 16'h0001, 1'b0);
    checks++; if (wr_count !== 16'hFFFE) begin errors++; $display("FAIL wrap_fffe got=%h exp=fffe", wr_count); end
    do_write(8'd2, 16'h0002, 1'b0);
    checks++; if (wr_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_ffff got=%h exp=ffff", wr_count); end
    do_write(8'd3, 16'h0003, 1'b0);
    checks++; if (wr_count !== 16'h0000) begin errors++; $display("FAIL wrap_zero got=%h exp=0000", wr_count); end
    checks++; if (dirty !== 1'b1) begin errors++; $display("FAIL wrap_dirty got=%b exp=1", dirty); end
    checks++; if ({addr_err, wr_ack} !== 2'b01) begin errors++; $display("FAIL wrap_flags got=%b exp=01", {addr_err, wr_ack}); end
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_write_commit();
    test_addr_err();
    test_coincide();
    test_held_strobes();
    test_reset_interactions();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_demux_32_w_shadow.md
DATA_DEMUX_32_W_SHADOW -- requirements
Module: data_demux_32_w_shadow

Interface
REQ-001 SHALL have parameter: DATA_W, 16, width of every data word (fixed; other values unsupported).
REQ-002 SHALL have port: clk  in  1  system clock, all logic on rising edge.
REQ-003 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port: data_lock  in  1  write strobe, rising-edge detected.
REQ-005 SHALL have port: selector  in  8  write address, valid range 0..31.
REQ-006 SHALL have port: data_in  in  16  write data.
REQ-007 SHALL have port: commit  in  1  shadow-to-output transfer strobe, rising-edge detected.
REQ-008 SHALL have ports: data_0 .. data_31  out  16 each  committed register values.
REQ-009 SHALL have port: wr_ack  out  1  one-cycle pulse, write accepted.
REQ-010 SHALL have port: addr_err  out  1  one-cycle pulse, write rejected (selector > 31).
REQ-011 SHALL have port: commit_ack  out  1  one-cycle pulse, commit performed.
REQ-012 SHALL have port: dirty  out  1  shadow holds at least one uncommitted write.
REQ-013 SHALL have port: wr_count  out  16  count of accepted writes since reset.

Function
REQ-014 SHALL hold 32 internal 16-bit shadow registers (shadow_0..shadow_31) separate from the outputs.
REQ-015 SHALL register data_lock and commit each cycle (lock_d, commit_d); write event = data_lock & !lock_d; commit event = commit & !commit_d.
REQ-016 SHALL, on a write event with selector 0..31, load shadow[selector] <= data_in at that same clock edge.
REQ-017 SHALL, on an accepted write, set dirty=1, pulse wr_ack=1 for exactly the following cycle, increment wr_count by 1.
REQ-018 SHALL, on a write event with selector 32..255, leave all shadows, dirty and wr_count unchanged and pulse addr_err=1 for the following cycle.
REQ-019 SHALL wrap wr_count from 0xFFFF to 0x0000 without any flag.
REQ-020 SHALL, on a commit event, copy all 32 shadows to data_0..data_31 in one edge (atomic), clear dirty, pulse commit_ack for the following cycle.
REQ-021 SHALL perform a commit event even when dirty=0 (outputs rewritten with identical values, commit_ack still pulses).
REQ-022 SHALL, when write and commit events coincide, commit the pre-write shadow contents, apply the write to the shadow, and leave dirty=1.
REQ-023 SHALL keep data_0..data_31 constant between commit events regardless of writes.
REQ-024 SHALL treat data_lock or commit held high as a single event; a new event requires a low cycle.
REQ-025 SHALL sample selector and data_in only in the event cycle; values at other times are ignored.
REQ-026 SHALL have wr_ack, addr_err, commit_ack low in all cycles not following an event.

Reset
REQ-027 SHALL, while reset=1, clear all shadows, data_0..data_31, dirty, wr_ack, addr_err, commit_ack, wr_count to 0.
REQ-028 SHALL keep lock_d/commit_d tracking their inputs during reset, so a strobe held high across reset release produces no event.
REQ-029 SHALL ignore events in any cycle with reset=1; reset mid-sequence discards uncommitted shadow writes.

Verification
REQ-030 SHALL cover: reset, write sel=5 data=0xABCD -> next cycle wr_ack=1, dirty=1, wr_count=1, data_5 still 0x0000.
REQ-031 SHALL cover: then commit pulse -> data_5=0xABCD same edge as event, commit_ack=1 next cycle, dirty=0, other outputs 0.
REQ-032 SHALL cover: write sel=32 data=0x1234 -> addr_err=1, wr_ack=0, wr_count unchanged, no shadow/output change.
REQ-033 SHALL cover: write sel=3 data=0x5555 and commit rising in the same cycle -> data_3 keeps old value, dirty=1; second commit -> data_3=0x5555.
REQ-034 SHALL cover: data_lock held high 10 cycles -> exactly one write, one wr_ack; data_lock high across reset release -> no write.
REQ-035 SHALL cover: 65536 accepted writes from reset -> wr_count=0x0000, dirty=1.
